// File: rtl/spiral_scan_gen_if.sv
// Coordinate stream between the spiral generator and its downstream display driver.
interface spiral_scan_gen_if #(
  parameter int XW = 3,
  parameter int YW = 3,
  parameter int IW = 6
) ();
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [IW-1:0] idx;
  logic          last;

  modport master (output out_valid, x, y, idx, last, input out_ready);
  modport slave  (input out_valid, x, y, idx, last, output out_ready);
endinterface

// File: rtl/spiral_scan_gen.sv
// Inward spiral (x,y) generator over a COLS x ROWS grid with a valid/ready output stream.
// Optional back-to-back pass looping when SPIRAL_LOOP_EN is defined.
module spiral_scan_gen #(
  parameter int COLS = 8,
  parameter int ROWS = 8,
  parameter int XW   = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int YW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int IW   = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic start,
  input  logic dir,
  output logic busy,
  output logic done,
`ifdef SPIRAL_LOOP_EN
  input  logic       loop,
  output logic [7:0] pass_cnt,
`endif
  spiral_scan_gen_if.master bus
);

  localparam int NCELL = COLS * ROWS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {H_R = 2'd0, H_D = 2'd1, H_L = 2'd2, H_U = 2'd3} head_t;

  state_t        r_state, w_state_next;
  head_t         r_heading, w_heading_next;
  logic          r_dir, w_dir_next;
  logic          r_done, w_done_next;
  logic [XW-1:0] r_x, w_x_next, r_left, w_left_next, r_right, w_right_next;
  logic [YW-1:0] r_y, w_y_next, r_top, w_top_next, r_bottom, w_bottom_next;
  logic [IW-1:0] r_idx, w_idx_next;
`ifdef SPIRAL_LOOP_EN
  logic [7:0]    r_pass, w_pass_next;
`endif

  logic  w_xfer, w_last, w_at_bound, w_init;
  head_t w_turn_head, w_step_head;

  assign w_xfer = (r_state == S_RUN) && bus.out_ready;
  assign w_last = (r_state == S_RUN) && (r_idx == IW'(NCELL - 1));

  // cw rotates R->D->L->U, ccw rotates D->R->U->L: +1 / -1 on the heading code
  always_comb begin
    w_at_bound = 1'b0;
    unique case (r_heading)
      H_R: w_at_bound = (r_x == r_right);
      H_D: w_at_bound = (r_y == r_bottom);
      H_L: w_at_bound = (r_x == r_left);
      H_U: w_at_bound = (r_y == r_top);
    endcase
    w_turn_head = r_dir ? head_t'(r_heading - 2'd1) : head_t'(r_heading + 2'd1);
    w_step_head = w_at_bound ? w_turn_head : r_heading;
  end

  always_comb begin
    w_state_next   = r_state;
    w_heading_next = r_heading;
    w_dir_next     = r_dir;
    w_done_next    = r_done;
    w_x_next       = r_x;
    w_y_next       = r_y;
    w_idx_next     = r_idx;
    w_left_next    = r_left;
    w_right_next   = r_right;
    w_top_next     = r_top;
    w_bottom_next  = r_bottom;
`ifdef SPIRAL_LOOP_EN
    w_pass_next    = r_pass;
`endif
    w_init         = 1'b0;
    if (ena) begin
      w_done_next = 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_next = S_RUN;
            w_dir_next   = dir;
            w_init       = 1'b1;
`ifdef SPIRAL_LOOP_EN
            w_pass_next  = 8'd0;
`endif
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            if (w_last) begin
              w_done_next = 1'b1;
`ifdef SPIRAL_LOOP_EN
              w_pass_next = r_pass + 8'd1;
              if (loop) begin
                w_dir_next = dir;
                w_init     = 1'b1;
              end else begin
                w_state_next = S_DONE;
              end
`else
              w_state_next = S_DONE;
`endif
            end else begin
              w_idx_next = r_idx + IW'(1);
              // Completed leg: pull in the bound that leg just swept
              if (w_at_bound) begin
                unique case (r_heading)
                  H_R: if (r_dir) w_bottom_next = r_bottom - YW'(1);
                       else       w_top_next    = r_top + YW'(1);
                  H_D: if (r_dir) w_left_next   = r_left + XW'(1);
                       else       w_right_next  = r_right - XW'(1);
                  H_L: if (r_dir) w_top_next    = r_top + YW'(1);
                       else       w_bottom_next = r_bottom - YW'(1);
                  H_U: if (r_dir) w_right_next  = r_right - XW'(1);
                       else       w_left_next   = r_left + XW'(1);
                endcase
              end
              w_heading_next = w_step_head;
              unique case (w_step_head)
                H_R: w_x_next = r_x + XW'(1);
                H_D: w_y_next = r_y + YW'(1);
                H_L: w_x_next = r_x - XW'(1);
                H_U: w_y_next = r_y - YW'(1);
              endcase
            end
          end
        end
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
      if (w_init) begin
        w_x_next       = '0;
        w_y_next       = '0;
        w_idx_next     = '0;
        w_left_next    = '0;
        w_top_next     = '0;
        w_right_next   = XW'(COLS - 1);
        w_bottom_next  = YW'(ROWS - 1);
        w_heading_next = w_dir_next ? H_D : H_R;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_heading <= H_R;
      r_dir     <= 1'b0;
      r_done    <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_idx     <= '0;
      r_left    <= '0;
      r_right   <= '0;
      r_top     <= '0;
      r_bottom  <= '0;
`ifdef SPIRAL_LOOP_EN
      r_pass    <= 8'd0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_heading <= w_heading_next;
      r_dir     <= w_dir_next;
      r_done    <= w_done_next;
      r_x       <= w_x_next;
      r_y       <= w_y_next;
      r_idx     <= w_idx_next;
      r_left    <= w_left_next;
      r_right   <= w_right_next;
      r_top     <= w_top_next;
      r_bottom  <= w_bottom_next;
`ifdef SPIRAL_LOOP_EN
      r_pass    <= w_pass_next;
`endif
    end
  end

  assign bus.out_valid = (r_state == S_RUN);
  assign bus.x         = r_x;
  assign bus.y         = r_y;
  assign bus.idx       = r_idx;
  assign bus.last      = w_last;
  assign busy          = (r_state == S_RUN);
  assign done          = r_done;
`ifdef SPIRAL_LOOP_EN
  assign pass_cnt      = r_pass;
`endif

endmodule

// File: tb/tb_spiral_scan_gen.sv
// Bench for spiral_scan_gen: four grid sizes checked against a visited-grid spiral walk.
module tb_spiral_scan_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic dir = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b1;
  int   sel = 0;
  int   checks = 0;
  int   failures = 0;
  int   ex[64];
  int   ey[64];
  int   lx, ly;

  always #5 clk = ~clk;

  spiral_scan_gen_if #(.XW(2), .YW(2), .IW(4)) if_a ();
  spiral_scan_gen_if #(.XW(3), .YW(3), .IW(6)) if_b ();
  spiral_scan_gen_if #(.XW(1), .YW(3), .IW(3)) if_c ();
  spiral_scan_gen_if #(.XW(1), .YW(1), .IW(1)) if_d ();
  assign if_a.out_ready = ready;
  assign if_b.out_ready = ready;
  assign if_c.out_ready = ready;
  assign if_d.out_ready = ready;

  logic busy_a, busy_b, busy_c, busy_d, done_a, done_b, done_c, done_d;
`ifdef SPIRAL_LOOP_EN
  logic       loop = 1'b0;
  logic [7:0] pass_a, pass_b, pass_c, pass_d;
`endif

  spiral_scan_gen #(.COLS(4), .ROWS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start && sel == 0), .dir(dir),
    .busy(busy_a), .done(done_a),
`ifdef SPIRAL_LOOP_EN
    .loop(loop), .pass_cnt(pass_a),
`endif
    .bus(if_a));
  spiral_scan_gen #(.COLS(8), .ROWS(8)) u_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start && sel == 1), .dir(dir),
    .busy(busy_b), .done(done_b),
`ifdef SPIRAL_LOOP_EN
    .loop(loop), .pass_cnt(pass_b),
`endif
    .bus(if_b));
  spiral_scan_gen #(.COLS(1), .ROWS(5)) u_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start && sel == 2), .dir(dir),
    .busy(busy_c), .done(done_c),
`ifdef SPIRAL_LOOP_EN
    .loop(loop), .pass_cnt(pass_c),
`endif
    .bus(if_c));
  spiral_scan_gen #(.COLS(1), .ROWS(1)) u_d (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start && sel == 3), .dir(dir),
    .busy(busy_d), .done(done_d),
`ifdef SPIRAL_LOOP_EN
    .loop(loop), .pass_cnt(pass_d),
`endif
    .bus(if_d));

  int m_valid, m_x, m_y, m_idx, m_last, m_busy, m_done;
  always_comb begin
    m_valid = 0; m_x = 0; m_y = 0; m_idx = 0; m_last = 0; m_busy = 0; m_done = 0;
    case (sel)
      0: begin m_valid = int'(if_a.out_valid); m_x = int'(if_a.x); m_y = int'(if_a.y);
               m_idx = int'(if_a.idx); m_last = int'(if_a.last); m_busy = int'(busy_a); m_done = int'(done_a); end
      1: begin m_valid = int'(if_b.out_valid); m_x = int'(if_b.x); m_y = int'(if_b.y);
               m_idx = int'(if_b.idx); m_last = int'(if_b.last); m_busy = int'(busy_b); m_done = int'(done_b); end
      2: begin m_valid = int'(if_c.out_valid); m_x = int'(if_c.x); m_y = int'(if_c.y);
               m_idx = int'(if_c.idx); m_last = int'(if_c.last); m_busy = int'(busy_c); m_done = int'(done_c); end
      default: begin m_valid = int'(if_d.out_valid); m_x = int'(if_d.x); m_y = int'(if_d.y);
               m_idx = int'(if_d.idx); m_last = int'(if_d.last); m_busy = int'(busy_d); m_done = int'(done_d); end
    endcase
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: walk forward, turn whenever the next cell is off-grid or already visited
  task automatic build(input int c, input int r, input bit d);
    bit vis[16][16];
    int dx[4] = '{1, 0, -1, 0};
    int dy[4] = '{0, 1, 0, -1};
    int x = 0, y = 0, h, nx, ny;
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) vis[i][j] = 1'b0;
    h = d ? 1 : 0;
    for (int i = 0; i < c * r; i++) begin
      ex[i] = x; ey[i] = y; vis[x][y] = 1'b1;
      if (i < c * r - 1) begin
        nx = x + dx[h]; ny = y + dy[h];
        if (nx < 0 || nx >= c || ny < 0 || ny >= r || vis[nx][ny]) begin
          h = d ? (h + 3) % 4 : (h + 1) % 4;
          nx = x + dx[h]; ny = y + dy[h];
        end
        x = nx; y = ny;
      end
    end
  endtask

  task automatic run(input int k, input int c, input int r, input bit d, input bit rnd,
                     input int inj, input int ena_at, input int stop_at, input bit lp, input bit cont);
    int n = 0, cyc = 0, nc = c * r;
    bit frozen = 1'b0;
    sel = k;
    build(c, r, d);
    if (!cont) begin
      dir = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    check("first_valid", m_valid, 1);
    while (n < nc && cyc < 4000 && n != stop_at) begin
      if (n == ena_at && !frozen) begin
        frozen = 1'b1; ena = 1'b0; ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("ena_hold_x", m_x, ex[n]);
          check("ena_hold_idx", m_idx, n);
        end
        ena = 1'b1;
      end
      check("valid", m_valid, 1);
      check("busy", m_busy, 1);
      check("x", m_x, ex[n]);
      check("y", m_y, ey[n]);
      check("idx", m_idx, n);
      check("last", m_last, int'(n == nc - 1));
      start = (n == inj);
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ready) begin
        $display("xfer dut=%0d idx=%0d x=%0d y=%0d last=%0d", k, m_idx, m_x, m_y, m_last);
        lx = m_x; ly = m_y;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
    if (cyc >= 4000) check("timeout", n, nc);
    if (n == nc) begin
      check("done_pulse", m_done, 1);
      if (lp) begin
        check("loop_valid", m_valid, 1);
        check("loop_idx", m_idx, 0);
        check("loop_x", m_x, 0);
        check("loop_y", m_y, 0);
      end else begin
        check("valid_drop", m_valid, 0);
        @(negedge clk);
        check("done_clear", m_done, 0);
        check("idle_busy", m_busy, 0);
      end
      if (!rnd && ena_at < 0) check("cycles", cyc, nc);
    end
  endtask

  initial begin
    sel = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", m_valid, 0);
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    check("rst_last", m_last, 0);
    check("rst_x", m_x, 0);
    check("rst_y", m_y, 0);
    check("rst_idx", m_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 4, 3, 1'b0, 1'b0, -1, -1, -1, 1'b0, 1'b0);
    check("cw43_final_x", lx, 2);
    check("cw43_final_y", ly, 1);
    run(0, 4, 3, 1'b1, 1'b0, -1, -1, -1, 1'b0, 1'b0);
    check("ccw43_final_x", lx, 2);
    check("ccw43_final_y", ly, 1);
    run(1, 8, 8, 1'b0, 1'b1, -1, -1, -1, 1'b0, 1'b0);
    check("cw88_final_x", lx, 3);
    check("cw88_final_y", ly, 4);
    run(1, 8, 8, 1'b1, 1'b1, -1, -1, -1, 1'b0, 1'b0);
    run(2, 1, 5, 1'b0, 1'b0, -1, -1, -1, 1'b0, 1'b0);
    check("line_final_y", ly, 4);
    run(2, 1, 5, 1'b1, 1'b0, -1, -1, -1, 1'b0, 1'b0);
    run(3, 1, 1, 1'b0, 1'b0, -1, -1, -1, 1'b0, 1'b0);
    run(0, 4, 3, 1'b0, 1'b0, 5, -1, -1, 1'b0, 1'b0);
    run(0, 4, 3, 1'b1, 1'b0, -1, 4, -1, 1'b0, 1'b0);

    run(0, 4, 3, 1'b0, 1'b0, -1, -1, 7, 1'b0, 1'b0);
    check("pre_rst_idx", m_idx, 7);
    rst_n = 1'b0;
    #1;
    check("abort_valid", m_valid, 0);
    check("abort_busy", m_busy, 0);
    check("abort_x", m_x, 0);
    check("abort_y", m_y, 0);
    check("abort_idx", m_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_no_done", m_done, 0);
    @(negedge clk);
    check("abort_no_done2", m_done, 0);
    check("abort_idle", m_busy, 0);

`ifdef SPIRAL_LOOP_EN
    check("pass_idle", int'(pass_a), 0);
    loop = 1'b1;
    run(0, 4, 3, 1'b0, 1'b0, -1, -1, -1, 1'b1, 1'b0);
    check("pass_one", int'(pass_a), 1);
    loop = 1'b0;
    run(0, 4, 3, 1'b0, 1'b0, -1, -1, -1, 1'b0, 1'b1);
    check("pass_two", int'(pass_a), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
